// File: rtl/alu_dispatch_if.sv
// Instruction-in and writeback-out handshake bundle for alu_dispatch.
// slave is the dispatcher view; master is the instruction source / register file view.
interface alu_dispatch_if #(
  parameter int unsigned DST_W = 3
);
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in_op;
  logic [7:0]       in_a;
  logic [7:0]       in_b;
  logic [DST_W-1:0] in_dst;

  logic             wb_valid;
  logic             wb_ready;
  logic [DST_W-1:0] wb_dst;
  logic [7:0]       wb_data;
  logic             wb_hi;

  modport master (
    output in_valid, in_op, in_a, in_b, in_dst,
    input  in_ready,
    input  wb_valid, wb_dst, wb_data, wb_hi,
    output wb_ready
  );

  modport slave (
    input  in_valid, in_op, in_a, in_b, in_dst,
    output in_ready,
    output wb_valid, wb_dst, wb_data, wb_hi,
    input  wb_ready
  );
endinterface

// File: rtl/alu_dispatch.sv
// Initiator for the combinational ALU: issues one instruction, captures result/flags, writes back.
// Define ALU_DISPATCH_MULHI_EN to add a second writeback beat carrying the MUL high byte.
module alu_dispatch #(
  parameter int unsigned DST_W        = 3,
  parameter int unsigned ISSUE_CYCLES = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  alu_dispatch_if.slave       bus,
  output logic                alu_enable,
  output logic [7:0]          alu_operation,
  output logic [7:0]          alu_op1,
  output logic [7:0]          alu_op2,
  output logic                alu_cpu_carry,
  input  logic [7:0]          alu_result_l,
  input  logic [7:0]          alu_result_h,
  input  logic                alu_carry,
  input  logic                alu_zero,
  input  logic                alu_sign,
  output logic                flag_c,
  output logic                flag_z,
  output logic                flag_s,
  input  logic                flag_we,
  input  logic [2:0]          flag_wdata
);

  localparam int unsigned CNT_W = (ISSUE_CYCLES > 1) ? $clog2(ISSUE_CYCLES) : 1;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
`ifdef ALU_DISPATCH_MULHI_EN
    WB_HI,
`endif
    WB_LO
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [7:0]       op_q, a_q, b_q;
  logic [DST_W-1:0] dst_q;
  logic [7:0]       res_l_q;
  logic             accept, capture;

`ifdef ALU_DISPATCH_MULHI_EN
  logic [7:0]       res_h_q;
  logic             is_mul;
  assign is_mul = (op_q[7:2] == 6'b100100);
`else
  logic             unused_res_h;
  assign unused_res_h = ^alu_result_h;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    capture = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          accept  = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (cnt_q == '0) begin
          capture = 1'b1;
          state_d = WB_LO;
        end
      end
      WB_LO: begin
        if (bus.wb_ready) begin
`ifdef ALU_DISPATCH_MULHI_EN
          state_d = is_mul ? WB_HI : IDLE;
`else
          state_d = IDLE;
`endif
        end
      end
`ifdef ALU_DISPATCH_MULHI_EN
      WB_HI: begin
        if (bus.wb_ready) state_d = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready = (state_q == IDLE);
    alu_enable   = (state_q == ISSUE);
    bus.wb_valid = 1'b0;
    bus.wb_data  = res_l_q;
    bus.wb_dst   = dst_q;
    bus.wb_hi    = 1'b0;
    if (state_q == WB_LO) bus.wb_valid = 1'b1;
`ifdef ALU_DISPATCH_MULHI_EN
    // High beat targets the next register, wrapping at the top of the file.
    if (state_q == WB_HI) begin
      bus.wb_valid = 1'b1;
      bus.wb_data  = res_h_q;
      bus.wb_dst   = dst_q + DST_W'(1);
      bus.wb_hi    = 1'b1;
    end
`endif
  end

  assign alu_operation = op_q;
  assign alu_op1       = a_q;
  assign alu_op2       = b_q;
  assign alu_cpu_carry = flag_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      dst_q   <= '0;
      res_l_q <= '0;
    end else begin
      if (accept) begin
        cnt_q <= CNT_W'(ISSUE_CYCLES - 1);
        op_q  <= bus.in_op;
        a_q   <= bus.in_a;
        b_q   <= bus.in_b;
        dst_q <= bus.in_dst;
      end else if (state_q == ISSUE && cnt_q != '0) begin
        cnt_q <= cnt_q - 1'b1;
      end
      if (capture) res_l_q <= alu_result_l;
    end
  end

`ifdef ALU_DISPATCH_MULHI_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       res_h_q <= '0;
    else if (capture) res_h_q <= alu_result_h;
  end
`endif

  // Flags only move at capture or an idle external load, so cpu_carry is frozen across ISSUE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_c <= 1'b0;
      flag_z <= 1'b0;
      flag_s <= 1'b0;
    end else if (capture) begin
      flag_c <= alu_carry;
      flag_z <= alu_zero;
      flag_s <= alu_sign;
    end else if (state_q == IDLE && flag_we) begin
      {flag_c, flag_z, flag_s} <= flag_wdata;
    end
  end

endmodule

// File: tb/tb_alu_dispatch.sv
// Randomised and directed bench for alu_dispatch against a transaction-queue reference model.
module tb_alu_dispatch;
  localparam int unsigned DST_W = 3;
  localparam int unsigned ISSUE = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_dispatch_if #(.DST_W(DST_W)) bus();

  logic       alu_enable, alu_cpu_carry;
  logic [7:0] alu_operation, alu_op1, alu_op2;
  logic [7:0] alu_result_l, alu_result_h;
  logic       alu_carry, alu_zero, alu_sign;
  logic       flag_c, flag_z, flag_s;
  logic       flag_we;
  logic [2:0] flag_wdata;

  alu_dispatch #(.DST_W(DST_W), .ISSUE_CYCLES(ISSUE)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .alu_enable(alu_enable), .alu_operation(alu_operation),
    .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_cpu_carry(alu_cpu_carry),
    .alu_result_l(alu_result_l), .alu_result_h(alu_result_h),
    .alu_carry(alu_carry), .alu_zero(alu_zero), .alu_sign(alu_sign),
    .flag_c(flag_c), .flag_z(flag_z), .flag_s(flag_s),
    .flag_we(flag_we), .flag_wdata(flag_wdata)
  );

  // Behavioural ALU: {hi[18:11], lo[10:3], c, z, s}; unknown opcodes give all zeros.
  function automatic logic [18:0] alu_fn(input logic [7:0] op, input logic [7:0] a,
                                         input logic [7:0] b, input logic cin);
    int s;
    int p;
    logic [7:0] lo;
    logic c;
    lo = 8'h00;
    c  = 1'b0;
    case (op)
      8'h80: begin s = int'(a) + int'(b);           lo = s[7:0]; c = s[8]; end
      8'h88: begin s = int'(a) + int'(b) + int'(cin); lo = s[7:0]; c = s[8]; end
      8'h84: begin s = int'(a) - int'(b);           lo = s[7:0]; c = (b > a); end
      8'hA0: lo = a & b;
      8'hA8: lo = a | b;
      8'hB0: lo = a ^ b;
      8'h90, 8'h91, 8'h92, 8'h93: begin
        p = int'(a) * int'(b);
        return {p[15:8], p[7:0], (p > 255), (p == 0), p[15]};
      end
      default: return '0;
    endcase
    return {8'h00, lo, c, (lo == 8'h00), lo[7]};
  endfunction

  assign {alu_result_h, alu_result_l, alu_carry, alu_zero, alu_sign} =
    alu_fn(alu_operation, alu_op1, alu_op2, alu_cpu_carry);

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: pending issue countdown plus a queue of writeback beats.
  typedef struct {
    logic [7:0]       data;
    logic [DST_W-1:0] dst;
    logic             hi;
  } beat_t;

  beat_t       q[$];
  int          m_issue;
  logic        m_c, m_z, m_s;
  logic [2:0]  m_pend;
  logic [7:0]  m_op, m_a, m_b;
  logic [18:0] m_r;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_issue = 0;
      q.delete();
      {m_c, m_z, m_s} = 3'b000;
      m_op = 8'h00; m_a = 8'h00; m_b = 8'h00;
    end else if (m_issue > 0) begin
      m_issue--;
      if (m_issue == 0) {m_c, m_z, m_s} = m_pend;
    end else if (q.size() > 0) begin
      if (bus.wb_ready) void'(q.pop_front());
    end else begin
      if (flag_we) {m_c, m_z, m_s} = flag_wdata;
      if (bus.in_valid) begin
        m_op = bus.in_op; m_a = bus.in_a; m_b = bus.in_b;
        m_r = alu_fn(bus.in_op, bus.in_a, bus.in_b, m_c);
        m_pend = m_r[2:0];
        q.push_back('{data: m_r[10:3], dst: bus.in_dst, hi: 1'b0});
`ifdef ALU_DISPATCH_MULHI_EN
        if (bus.in_op >= 8'h90 && bus.in_op <= 8'h93)
          q.push_back('{data: m_r[18:11],
                        dst: DST_W'((int'(bus.in_dst) + 1) % (1 << DST_W)), hi: 1'b1});
`endif
        m_issue = ISSUE;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("in_ready", bus.in_ready, (m_issue == 0 && q.size() == 0));
      chk("wb_valid", bus.wb_valid, (m_issue == 0 && q.size() != 0));
      if (m_issue == 0 && q.size() != 0) begin
        chk("wb_data", bus.wb_data, q[0].data);
        chk("wb_dst", bus.wb_dst, q[0].dst);
        chk("wb_hi", bus.wb_hi, q[0].hi);
      end
      chk("flags", {flag_c, flag_z, flag_s}, {m_c, m_z, m_s});
      chk("alu_enable", alu_enable, (m_issue > 0));
      if (m_issue > 0) begin
        chk("alu_operation", alu_operation, m_op);
        chk("alu_op1", alu_op1, m_a);
        chk("alu_op2", alu_op2, m_b);
        chk("alu_cpu_carry", alu_cpu_carry, m_c);
      end
    end
  end

  task automatic send(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b,
                      input logic [DST_W-1:0] dst);
    int n;
    @(posedge clk); #2;
    bus.in_valid = 1'b1; bus.in_op = op; bus.in_a = a; bus.in_b = b; bus.in_dst = dst;
    n = 0;
    forever begin
      @(negedge clk);
      if (bus.in_ready) break;
      n++;
      if (n > 50) begin chk("accept_timeout", 32'd0, 32'd1); break; end
    end
    @(posedge clk); #2;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_beat(output int lat);
    lat = 0;
    forever begin
      @(negedge clk);
      lat++;
      if (bus.wb_valid) break;
      if (lat > 50) begin chk("beat_timeout", 32'd0, 32'd1); break; end
    end
  endtask

  logic [7:0] ops [13] = '{8'h80, 8'h84, 8'h88, 8'hA0, 8'hA8, 8'hB0,
                           8'h90, 8'h91, 8'h92, 8'h93, 8'h00, 8'hFF, 8'h13};

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int lat;
    bus.in_valid = 1'b0; bus.in_op = '0; bus.in_a = '0; bus.in_b = '0; bus.in_dst = '0;
    bus.wb_ready = 1'b1; flag_we = 1'b0; flag_wdata = '0;

    repeat (3) @(negedge clk);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_wb_valid", bus.wb_valid, 0);
    chk("rst_flags", {flag_c, flag_z, flag_s}, 3'b000);
    chk("rst_alu_enable", alu_enable, 0);
    chk("rst_alu_op", {alu_operation, alu_op1, alu_op2}, 24'h0);
    @(posedge clk); #2 rst_n = 1'b1;

    // ADC with carry out, then ADC consuming that carry.
    send(8'h88, 8'hF0, 8'h20, 3'd2);
    wait_beat(lat);
    chk("t1_latency", lat, 1 + ISSUE);
    chk("t1_data", bus.wb_data, 8'h10);
    chk("t1_dst", bus.wb_dst, 2);
    chk("t1_hi", bus.wb_hi, 0);
    chk("t1_flags", {flag_c, flag_z, flag_s}, 3'b100);

    send(8'h88, 8'h01, 8'h01, 3'd3);
    @(negedge clk);
    chk("t2_enable", alu_enable, 1);
    chk("t2_cpu_carry", alu_cpu_carry, 1);
    wait_beat(lat);
    chk("t2_data", bus.wb_data, 8'h03);
    chk("t2_flag_c", flag_c, 0);

    // MUL into the top register: high beat wraps to register 0.
    send(8'h90, 8'h10, 8'h20, 3'd7);
    wait_beat(lat);
    chk("t3_lo_data", bus.wb_data, 8'h00);
    chk("t3_lo_dst", bus.wb_dst, 7);
    chk("t3_lo_hi", bus.wb_hi, 0);
    chk("t3_z", flag_z, 0);
    @(negedge clk);
`ifdef ALU_DISPATCH_MULHI_EN
    chk("t3_hi_valid", bus.wb_valid, 1);
    chk("t3_hi_data", bus.wb_data, 8'h02);
    chk("t3_hi_dst", bus.wb_dst, 0);
    chk("t3_hi_hi", bus.wb_hi, 1);
`else
    chk("t3_single_beat", bus.wb_valid, 0);
`endif

    // Writeback stall with in_valid pulses that must not be taken.
    bus.wb_ready = 1'b0;
    send(8'h80, 8'h12, 8'h34, 3'd1);
    wait_beat(lat);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #2;
      bus.in_valid = (i % 2 == 0); bus.in_op = 8'hA0; bus.in_dst = 3'd6;
      @(negedge clk);
      chk("t4_valid", bus.wb_valid, 1);
      chk("t4_data", bus.wb_data, 8'h46);
      chk("t4_dst", bus.wb_dst, 1);
      chk("t4_in_ready", bus.in_ready, 0);
    end
    @(posedge clk); #2 bus.in_valid = 1'b0; bus.wb_ready = 1'b1;
    @(negedge clk); @(negedge clk);
    chk("t4_done_idle", bus.in_ready, 1);
    chk("t4_done_valid", bus.wb_valid, 0);

    // External flag load in IDLE; held request during ISSUE/WB must be ignored.
    @(posedge clk); #2 flag_we = 1'b1; flag_wdata = 3'b101;
    @(posedge clk); #2 flag_we = 1'b0;
    @(negedge clk);
    chk("t5_flag_load", {flag_c, flag_z, flag_s}, 3'b101);
    bus.wb_ready = 1'b0;
    send(8'h00, 8'h55, 8'hAA, 3'd4);
    flag_we = 1'b1; flag_wdata = 3'b010;
    wait_beat(lat);
    chk("t5_rsv_data", bus.wb_data, 8'h00);
    chk("t5_rsv_flags", {flag_c, flag_z, flag_s}, 3'b000);
    repeat (2) @(negedge clk);
    @(posedge clk); #2 flag_we = 1'b0; bus.wb_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("t5_flags_kept", {flag_c, flag_z, flag_s}, 3'b000);

    // Reset while a beat is waiting.
    bus.wb_ready = 1'b0;
    send(8'h80, 8'hFF, 8'h01, 3'd5);
    wait_beat(lat);
    chk("t6_pre_flags", {flag_c, flag_z, flag_s}, 3'b110);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_wb_valid", bus.wb_valid, 0);
    chk("t6_in_ready", bus.in_ready, 1);
    chk("t6_flags", {flag_c, flag_z, flag_s}, 3'b000);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1; bus.wb_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t6_no_beat", bus.wb_valid, 0);
    end

    // Random traffic.
    for (int i = 0; i < 4000; i++) begin
      @(posedge clk); #2;
      bus.in_valid = ($urandom_range(0, 2) != 0);
      bus.in_op    = ops[$urandom_range(0, 12)];
      bus.in_a     = 8'($urandom);
      bus.in_b     = 8'($urandom);
      bus.in_dst   = DST_W'($urandom);
      bus.wb_ready = ($urandom_range(0, 3) != 0);
      flag_we      = ($urandom_range(0, 9) == 0);
      flag_wdata   = 3'($urandom);
    end
    @(posedge clk); #2;
    bus.in_valid = 1'b0; flag_we = 1'b0; bus.wb_ready = 1'b1;
    repeat (10) @(negedge clk);
    chk("drain_idle", bus.in_ready, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
